// File: rtl/mem_port_pkg.sv
// Shared encodings, state type and arbitration helper for the SRAM test-macro port sequencer.
package mem_port_pkg;

  localparam int MPS_ADDR_W = 17;

  localparam logic [1:0] RW_IDLE = 2'b00;
  localparam logic [1:0] RW_WR   = 2'b01;
  localparam logic [1:0] RW_RD   = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RTZ,
    DONE
  } state_t;

  // With both ports valid the pointer decides; a lone requester always wins.
  function automatic logic pickPort(input logic [1:0] valid, input logic ptr);
    if (valid == 2'b11) begin
      return ptr;
    end
    return valid[1];
  endfunction

endpackage

// File: rtl/mps_sync.sv
// N-bit multi-flop synchronizer for the macro's asynchronous acknowledges.
module mps_sync #(
  parameter int N      = 1,
  parameter int STAGES = 2
) (
  input  logic         i_clk,
  input  logic         i_rstN,
  input  logic [N-1:0] i_d,
  output logic [N-1:0] o_q
);

  localparam int DEPTH = (STAGES < 2) ? 2 : STAGES;

  logic [N-1:0] r_stage [DEPTH];

  always_ff @(posedge i_clk) begin
    if (!i_rstN) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_stage[i] <= '0;
      end
    end else begin
      r_stage[0] <= i_d;
      for (int i = 1; i < DEPTH; i++) begin
        r_stage[i] <= r_stage[i-1];
      end
    end
  end

  assign o_q = r_stage[DEPTH-1];

endmodule

// File: rtl/mem_port_sequencer.sv
// Two-port round-robin master for the SRAM test macro's four-phase return-to-zero handshake.
// Optional handshake watchdog enabled by defining MPS_TIMEOUT_EN.
module mem_port_sequencer
  import mem_port_pkg::*;
#(
  parameter int ADDR_W      = MPS_ADDR_W,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              req_valid0,
  input  logic              req_valid1,
  output logic              req_ready0,
  output logic              req_ready1,
  input  logic              req_read0,
  input  logic              req_read1,
  input  logic [ADDR_W-1:0] req_addr0,
  input  logic [ADDR_W-1:0] req_addr1,
  input  logic [7:0]        req_wdata0,
  input  logic [7:0]        req_wdata1,
  output logic              rsp_valid0,
  output logic              rsp_valid1,
  output logic [7:0]        rsp_rdata0,
  output logic [7:0]        rsp_rdata1,
  output logic              rsp_err0,
  output logic              rsp_err1,
  output logic [ADDR_W-1:0] A,
  output logic [1:0]        RW,
  output logic [3:0]        W1,
  output logic [3:0]        W2,
  input  logic [1:0]        WdataAck,
  input  logic [3:0]        R1,
  input  logic [3:0]        R2,
  output logic [1:0]        RDataAck,
  input  logic              Ack
);

  localparam int SYNC_DEPTH = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
  localparam int SET_W      = $clog2(SYNC_DEPTH + 1);

  logic              w_ackS;
  logic [1:0]        w_wdAckS;
  state_t            r_state;
  state_t            w_nextState;
  logic              r_port;
  logic              r_read;
  logic              r_rrPtr;
  logic [SET_W-1:0]  r_settleCnt;
  logic              w_settled;
  logic [ADDR_W-1:0] r_A;
  logic [1:0]        r_RW;
  logic [3:0]        r_W1;
  logic [3:0]        r_W2;
  logic [1:0]        r_RDataAck;
  logic [1:0]        r_rspValid;
  logic [7:0]        r_rdata0;
  logic [7:0]        r_rdata1;
  logic [ADDR_W-1:0] w_nextA;
  logic [1:0]        w_nextRW;
  logic [3:0]        w_nextW1;
  logic [3:0]        w_nextW2;
  logic [1:0]        w_nextRDataAck;
  logic [1:0]        w_nextValid;
  logic [1:0]        w_ready;
  logic              w_accept;
  logic              w_capture;
  logic              w_grantPort;
  logic              w_selRead;
  logic [ADDR_W-1:0] w_selAddr;
  logic [7:0]        w_selWdata;
  logic [1:0]        w_portMask;
  logic              w_reqDone;

  mps_sync #(
    .N      (3),
    .STAGES (SYNC_DEPTH)
  ) u_sync (
    .i_clk  (CLK),
    .i_rstN (RSTn),
    .i_d    ({WdataAck, Ack}),
    .o_q    ({w_wdAckS, w_ackS})
  );

`ifdef MPS_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

  logic [TO_W-1:0] r_toCnt;
  logic            w_toHit;
  logic            w_nextErr;
  logic            r_err0;
  logic            r_err1;

  assign w_toHit = (r_toCnt == TO_W'(TIMEOUT_CYC - 1));

  // Watchdog restarts on every state change so REQ and RTZ each get the full budget.
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      r_toCnt <= '0;
      r_err0  <= 1'b0;
      r_err1  <= 1'b0;
    end else begin
      if (w_nextState != r_state) begin
        r_toCnt <= '0;
      end else if (r_state == REQ || r_state == RTZ) begin
        r_toCnt <= r_toCnt + 1'b1;
      end
      r_err0 <= w_nextValid[0] & w_nextErr;
      r_err1 <= w_nextValid[1] & w_nextErr;
    end
  end

  assign rsp_err0 = r_err0;
  assign rsp_err1 = r_err1;
`else
  logic [31:0] w_unusedTimeout;

  assign w_unusedTimeout = 32'(TIMEOUT_CYC);
  assign rsp_err0        = 1'b0;
  assign rsp_err1        = 1'b0;
`endif

  // The synchronizer is cleared by reset, so grants wait until it holds a real Ack sample.
  assign w_settled   = (r_settleCnt == SET_W'(SYNC_DEPTH));
  assign w_grantPort = pickPort({req_valid1, req_valid0}, r_rrPtr);
  assign w_selRead   = w_grantPort ? req_read1  : req_read0;
  assign w_selAddr   = w_grantPort ? req_addr1  : req_addr0;
  assign w_selWdata  = w_grantPort ? req_wdata1 : req_wdata0;
  assign w_portMask  = r_port ? 2'b10 : 2'b01;
  assign w_reqDone   = w_ackS & (r_read | (w_wdAckS == 2'b11));

  always_comb begin
    w_nextState    = r_state;
    w_nextA        = r_A;
    w_nextRW       = r_RW;
    w_nextW1       = r_W1;
    w_nextW2       = r_W2;
    w_nextRDataAck = r_RDataAck;
    w_nextValid    = 2'b00;
    w_ready        = 2'b00;
    w_accept       = 1'b0;
    w_capture      = 1'b0;
`ifdef MPS_TIMEOUT_EN
    w_nextErr      = 1'b0;
`endif
    case (r_state)
      IDLE: begin
        if (w_settled && !w_ackS && (req_valid0 || req_valid1)) begin
          w_accept    = 1'b1;
          w_ready     = w_grantPort ? 2'b10 : 2'b01;
          w_nextState = REQ;
          w_nextA     = w_selAddr;
          w_nextRW    = w_selRead ? RW_RD : RW_WR;
          w_nextW1    = w_selRead ? 4'h0 : w_selWdata[3:0];
          w_nextW2    = w_selRead ? 4'h0 : w_selWdata[7:4];
        end
      end
      REQ: begin
        if (w_reqDone) begin
          w_capture      = r_read;
          w_nextState    = RTZ;
          w_nextA        = '0;
          w_nextRW       = RW_IDLE;
          w_nextW1       = 4'h0;
          w_nextW2       = 4'h0;
          w_nextRDataAck = r_read ? 2'b11 : 2'b00;
        end
`ifdef MPS_TIMEOUT_EN
        else if (w_toHit) begin
          w_nextState    = DONE;
          w_nextA        = '0;
          w_nextRW       = RW_IDLE;
          w_nextW1       = 4'h0;
          w_nextW2       = 4'h0;
          w_nextRDataAck = 2'b00;
          w_nextValid    = w_portMask;
          w_nextErr      = 1'b1;
        end
`endif
      end
      RTZ: begin
        if (!w_ackS) begin
          w_nextRDataAck = 2'b00;
          w_nextState    = DONE;
          w_nextValid    = w_portMask;
        end
`ifdef MPS_TIMEOUT_EN
        else if (w_toHit) begin
          w_nextRDataAck = 2'b00;
          w_nextState    = DONE;
          w_nextValid    = w_portMask;
          w_nextErr      = 1'b1;
        end
`endif
      end
      DONE: begin
        w_nextState = IDLE;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      r_state     <= IDLE;
      r_A         <= '0;
      r_RW        <= RW_IDLE;
      r_W1        <= 4'h0;
      r_W2        <= 4'h0;
      r_RDataAck  <= 2'b00;
      r_rspValid  <= 2'b00;
      r_rdata0    <= 8'h00;
      r_rdata1    <= 8'h00;
      r_port      <= 1'b0;
      r_read      <= 1'b0;
      r_rrPtr     <= 1'b0;
      r_settleCnt <= '0;
    end else begin
      r_state    <= w_nextState;
      r_A        <= w_nextA;
      r_RW       <= w_nextRW;
      r_W1       <= w_nextW1;
      r_W2       <= w_nextW2;
      r_RDataAck <= w_nextRDataAck;
      r_rspValid <= w_nextValid;
      if (!w_settled) begin
        r_settleCnt <= r_settleCnt + 1'b1;
      end
      if (w_accept) begin
        r_port  <= w_grantPort;
        r_read  <= w_selRead;
        r_rrPtr <= ~w_grantPort;
      end
      if (w_capture) begin
        if (r_port) begin
          r_rdata1 <= {R2, R1};
        end else begin
          r_rdata0 <= {R2, R1};
        end
      end
    end
  end

  // req_ready is a same-cycle acceptance strobe, so it is decoded rather than registered.
  assign req_ready0 = w_ready[0];
  assign req_ready1 = w_ready[1];
  assign rsp_valid0 = r_rspValid[0];
  assign rsp_valid1 = r_rspValid[1];
  assign rsp_rdata0 = r_rdata0;
  assign rsp_rdata1 = r_rdata1;
  assign A          = r_A;
  assign RW         = r_RW;
  assign W1         = r_W1;
  assign W2         = r_W2;
  assign RDataAck   = r_RDataAck;

endmodule

// File: tb/tb_mem_port_sequencer.sv
// Self-checking bench for mem_port_sequencer: macro model, request table and response scoreboard.
// Define MPS_TIMEOUT_EN for both bench and RTL to exercise the watchdog sequence.
module tb_mem_port_sequencer;

  localparam int ADDR_W      = 17;
  localparam int SYNC_STAGES = 2;
  localparam int TIMEOUT_CYC = 16;

  logic              CLK = 1'b0;
  logic              RSTn = 1'b0;
  logic [1:0]        reqValid = 2'b00;
  logic [1:0]        reqRead = 2'b00;
  logic [ADDR_W-1:0] reqAddr [2];
  logic [7:0]        reqWdata [2];
  logic              req_ready0, req_ready1;
  logic              rsp_valid0, rsp_valid1;
  logic [7:0]        rsp_rdata0, rsp_rdata1;
  logic              rsp_err0, rsp_err1;
  logic [ADDR_W-1:0] A;
  logic [1:0]        RW;
  logic [3:0]        W1, W2;
  logic [1:0]        WdataAck = 2'b00;
  logic [3:0]        R1 = 4'h0;
  logic [3:0]        R2 = 4'h0;
  logic [1:0]        RDataAck;
  logic              Ack = 1'b0;

  int   mCnt = 0;
  int   mDelay = 0;
  bit   mPartial = 1'b0;
  bit   mNoAck = 1'b0;
  bit   mHoldAck = 1'b0;
  logic [3:0] mR1 = 4'h0;
  logic [3:0] mR2 = 4'h0;

  int checks = 0;
  int passes = 0;
  int cycleCount = 0;
  int lastLatency = 0;
  logic tbPtr = 1'b0;

  typedef struct {
    logic       port;
    logic [7:0] rdata;
    logic       err;
    int         acceptCycle;
  } exp_t;

  typedef struct {
    int          port;
    logic        rd;
    logic [16:0] addr;
    logic [7:0]  wd;
    logic [3:0]  r1;
    logic [3:0]  r2;
    int          delay;
    logic [1:0]  expRW;
    logic [3:0]  expW1;
    logic [3:0]  expW2;
    logic [1:0]  expRdAck;
    logic [7:0]  expRdata;
  } vec_t;

  exp_t sbQ[$];
  int   grantLog[$];
  exp_t mon;
  vec_t vecs[5];

  mem_port_sequencer #(
    .ADDR_W      (ADDR_W),
    .SYNC_STAGES (SYNC_STAGES),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .CLK        (CLK),
    .RSTn       (RSTn),
    .req_valid0 (reqValid[0]),
    .req_valid1 (reqValid[1]),
    .req_ready0 (req_ready0),
    .req_ready1 (req_ready1),
    .req_read0  (reqRead[0]),
    .req_read1  (reqRead[1]),
    .req_addr0  (reqAddr[0]),
    .req_addr1  (reqAddr[1]),
    .req_wdata0 (reqWdata[0]),
    .req_wdata1 (reqWdata[1]),
    .rsp_valid0 (rsp_valid0),
    .rsp_valid1 (rsp_valid1),
    .rsp_rdata0 (rsp_rdata0),
    .rsp_rdata1 (rsp_rdata1),
    .rsp_err0   (rsp_err0),
    .rsp_err1   (rsp_err1),
    .A          (A),
    .RW         (RW),
    .W1         (W1),
    .W2         (W2),
    .WdataAck   (WdataAck),
    .R1         (R1),
    .R2         (R2),
    .RDataAck   (RDataAck),
    .Ack        (Ack)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cycleCount++;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual === expected) begin
      passes++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic reportTimeout(input string name);
    checks++;
    $display("[TB] FAIL %s: wait bound expired, got no event, expected one", name);
  endtask

  // Macro model: acks after mDelay REQ cycles, optionally half-acks the write data first.
  always @(negedge CLK) begin
    if (RW != 2'b00) begin
      mCnt++;
      if (!mNoAck && mCnt >= mDelay) begin
        Ack      = 1'b1;
        WdataAck = (mPartial && mCnt < mDelay + 5) ? 2'b01 : 2'b11;
        R1       = mR1;
        R2       = mR2;
      end
    end else begin
      mCnt = 0;
      if (!mHoldAck) begin
        Ack      = 1'b0;
        WdataAck = 2'b00;
      end
    end
  end

  // Scoreboard side: every rsp_valid must match the oldest accepted request.
  always @(negedge CLK) begin
    if (req_ready0 || req_ready1) begin
      checkOutput("oneReady", 32'(req_ready0 & req_ready1), 32'd0);
    end
    if (rsp_valid0 || rsp_valid1) begin
      if (sbQ.size() == 0) begin
        checks++;
        $display("[TB] FAIL unexpectedRsp: got rsp_valid=%b%b, expected none", rsp_valid1, rsp_valid0);
      end else begin
        mon = sbQ.pop_front();
        checkOutput("rspPort", 32'({rsp_valid1, rsp_valid0}), mon.port ? 32'd2 : 32'd1);
        checkOutput("rspRdata", 32'(mon.port ? rsp_rdata1 : rsp_rdata0), 32'(mon.rdata));
        checkOutput("rspErr", 32'(mon.port ? rsp_err1 : rsp_err0), 32'(mon.err));
        lastLatency = cycleCount - mon.acceptCycle;
      end
    end
  end

  task automatic applyStimulus(input int port, input logic rd, input logic [ADDR_W-1:0] addr,
                               input logic [7:0] wd, input logic [7:0] expRdata, input logic expErr);
    bit   got;
    exp_t e;
    got = 1'b0;
    @(posedge CLK); #1;
    reqValid[port] = 1'b1;
    reqRead[port]  = rd;
    reqAddr[port]  = addr;
    reqWdata[port] = wd;
    for (int i = 0; i < 400 && !got; i++) begin
      @(negedge CLK);
      if ((port == 0 && req_ready0) || (port == 1 && req_ready1)) got = 1'b1;
    end
    if (!got) begin
      reportTimeout("accept");
      reqValid[port] = 1'b0;
      return;
    end
    e.port        = port[0];
    e.rdata       = expRdata;
    e.err         = expErr;
    e.acceptCycle = cycleCount;
    sbQ.push_back(e);
    grantLog.push_back(port);
    tbPtr = ~port[0];
    @(posedge CLK); #1;
    reqValid[port] = 1'b0;
  endtask

  task automatic waitResponses();
    for (int i = 0; i < 600 && sbQ.size() != 0; i++) @(negedge CLK);
    if (sbQ.size() != 0) begin
      reportTimeout("drain");
      sbQ.delete();
    end
    repeat (4) @(negedge CLK);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL globalWatchdog: simulation still running, expected finish");
    $fatal(1, "[TB] global watchdog expired");
  end

  initial begin
    bit   gotRtz;
    bit   sawReady;
    logic firstExp;

    reqAddr[0]  = '0;
    reqAddr[1]  = '0;
    reqWdata[0] = 8'h00;
    reqWdata[1] = 8'h00;

    vecs[0] = '{0, 1'b0, 17'h11111, 8'h11, 4'h0, 4'h0, 5, 2'b01, 4'h1, 4'h1, 2'b00, 8'h00};
    vecs[1] = '{1, 1'b1, 17'h00ABC, 8'h00, 4'h5, 4'hA, 3, 2'b10, 4'h0, 4'h0, 2'b11, 8'hA5};
    vecs[2] = '{0, 1'b1, 17'h1F00F, 8'h77, 4'hC, 4'h3, 1, 2'b10, 4'h0, 4'h0, 2'b11, 8'h3C};
    vecs[3] = '{1, 1'b0, 17'h00001, 8'hA5, 4'h0, 4'h0, 2, 2'b01, 4'h5, 4'hA, 2'b00, 8'hA5};
    vecs[4] = '{0, 1'b0, 17'h1FFFF, 8'hFF, 4'h0, 4'h0, 0, 2'b01, 4'hF, 4'hF, 2'b00, 8'h3C};

    repeat (3) @(posedge CLK);
    #1;
    checkOutput("rst_A", 32'(A), 32'd0);
    checkOutput("rst_RW", 32'(RW), 32'd0);
    checkOutput("rst_W", 32'({W2, W1}), 32'd0);
    checkOutput("rst_RDataAck", 32'(RDataAck), 32'd0);
    checkOutput("rst_rspValid", 32'({rsp_valid1, rsp_valid0}), 32'd0);
    checkOutput("rst_rdata", 32'({rsp_rdata1, rsp_rdata0}), 32'd0);
    checkOutput("rst_err", 32'({rsp_err1, rsp_err0}), 32'd0);
    checkOutput("rst_ready", 32'({req_ready1, req_ready0}), 32'd0);
    RSTn = 1'b1;
    repeat (4) @(posedge CLK);

    for (int v = 0; v < 5; v++) begin
      mDelay = vecs[v].delay;
      mR1    = vecs[v].r1;
      mR2    = vecs[v].r2;
      applyStimulus(vecs[v].port, vecs[v].rd, vecs[v].addr, vecs[v].wd, vecs[v].expRdata, 1'b0);
      checkOutput($sformatf("v%0d_A", v), 32'(A), 32'(vecs[v].addr));
      checkOutput($sformatf("v%0d_RW", v), 32'(RW), 32'(vecs[v].expRW));
      checkOutput($sformatf("v%0d_W1", v), 32'(W1), 32'(vecs[v].expW1));
      checkOutput($sformatf("v%0d_W2", v), 32'(W2), 32'(vecs[v].expW2));
      gotRtz = 1'b0;
      for (int i = 0; i < 100 && !gotRtz; i++) begin
        @(negedge CLK);
        if (RW == 2'b00) gotRtz = 1'b1;
      end
      if (!gotRtz) begin
        reportTimeout($sformatf("v%0d_rtz", v));
      end else begin
        checkOutput($sformatf("v%0d_rtzRDataAck", v), 32'(RDataAck), 32'(vecs[v].expRdAck));
        checkOutput($sformatf("v%0d_rtzA", v), 32'(A), 32'd0);
        checkOutput($sformatf("v%0d_rtzW", v), 32'({W2, W1}), 32'd0);
      end
      waitResponses();
      checkOutput($sformatf("v%0d_idleRDataAck", v), 32'(RDataAck), 32'd0);
    end

    $display("[TB] minimum latency");
    mDelay = 0;
    applyStimulus(1, 1'b0, 17'h00002, 8'h12, 8'hA5, 1'b0);
    waitResponses();
    checkOutput("minLatency", 32'(lastLatency), 32'(3 + 2 * SYNC_STAGES));

    $display("[TB] partial write acknowledge");
    mDelay   = 2;
    mPartial = 1'b1;
    applyStimulus(0, 1'b0, 17'h02468, 8'h9C, 8'h3C, 1'b0);
    repeat (7) @(negedge CLK);
    checkOutput("partial_RWheld", 32'(RW), 32'(2'b01));
    checkOutput("partial_Wheld", 32'({W2, W1}), 32'h9C);
    waitResponses();
    mPartial = 1'b0;

    $display("[TB] back-to-back both ports");
    mDelay = 0;
    mR1    = 4'h7;
    mR2    = 4'h7;
    grantLog.delete();
    firstExp = tbPtr;
    fork
      begin
        for (int k = 0; k < 4; k++) applyStimulus(0, 1'b0, 17'(17'h00100 + k), 8'(8'h40 + k), 8'h3C, 1'b0);
      end
      begin
        for (int k = 0; k < 4; k++) applyStimulus(1, 1'b1, 17'(17'h00200 + k), 8'h00, 8'h77, 1'b0);
      end
    join
    waitResponses();
    checkOutput("b2b_grants", 32'(grantLog.size()), 32'd8);
    if (grantLog.size() == 8) begin
      for (int i = 0; i < 8; i++) begin
        checkOutput($sformatf("b2b_order%0d", i), 32'(grantLog[i]), 32'(firstExp ^ i[0]));
      end
    end

`ifdef MPS_TIMEOUT_EN
    $display("[TB] watchdog timeout");
    mNoAck = 1'b1;
    applyStimulus(0, 1'b1, 17'h00123, 8'h00, 8'h3C, 1'b1);
    waitResponses();
    checkOutput("to_latency", 32'(lastLatency), 32'(TIMEOUT_CYC + 1));
    checkOutput("to_RW", 32'(RW), 32'd0);
    checkOutput("to_A", 32'(A), 32'd0);
    mNoAck = 1'b0;
`endif

    $display("[TB] reset during REQ with Ack high");
    mDelay   = 1;
    mHoldAck = 1'b1;
    applyStimulus(0, 1'b0, 17'h0F0F0, 8'h5A, 8'h00, 1'b0);
    @(posedge CLK); #1;
    RSTn = 1'b0;
    @(posedge CLK); #1;
    RSTn  = 1'b1;
    sbQ.delete();
    tbPtr = 1'b0;
    checkOutput("rstMid_A", 32'(A), 32'd0);
    checkOutput("rstMid_RW", 32'(RW), 32'd0);
    checkOutput("rstMid_W", 32'({W2, W1}), 32'd0);
    checkOutput("rstMid_RDataAck", 32'(RDataAck), 32'd0);
    reqValid[1] = 1'b1;
    reqRead[1]  = 1'b0;
    reqAddr[1]  = 17'h00F00;
    reqWdata[1] = 8'h3C;
    sawReady    = 1'b0;
    repeat (8) begin
      @(negedge CLK);
      if (req_ready1) sawReady = 1'b1;
    end
    checkOutput("rstMid_noGrantWhileAck", 32'(sawReady), 32'd0);
    @(posedge CLK); #1;
    reqValid[1] = 1'b0;
    mHoldAck    = 1'b0;
    applyStimulus(1, 1'b0, 17'h00F00, 8'h3C, 8'h00, 1'b0);
    waitResponses();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
